// File: rtl/aes_pkg.sv
// Shared constants, types and the word-insertion helper for the AES block packer.
package aes_pkg;

  localparam int WORD_W = 32;
  localparam int WPB    = 4;
  localparam int BLK_W  = WORD_W * WPB;
  localparam int WCNT_W = $clog2(WPB) + 1;

  typedef logic [BLK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } pack_state_t;

  // Place word into slot idx of a block; slot 0 occupies the most significant bits.
  function automatic aes_block_t put_word(input aes_block_t blk,
                                          input logic [WCNT_W-1:0] idx,
                                          input logic [WORD_W-1:0] word);
    aes_block_t res;
    res = blk;
    for (int k = 0; k < WPB; k++) begin
      if (idx == WCNT_W'(k)) begin
        res[BLK_W-1-WORD_W*k -: WORD_W] = word;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO; each entry carries the 128-bit block plus its last flag.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             push,
  input  logic [BLK_W:0]   push_entry,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [BLK_W-1:0] head_data,
  output logic             head_last
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [BLK_W:0]   mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (cnt_r == CNT_W'(DEPTH));
  assign empty     = (cnt_r == {CNT_W{1'b0}});
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head_data = mem_r[rd_ptr_r][BLK_W-1:0];
  assign head_last = mem_r[rd_ptr_r][BLK_W];

  // Storage, pointers and occupancy; clear and reset empty the FIFO and zero its contents.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(BLK_W+1){1'b0}};
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(BLK_W+1){1'b0}};
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Packs 32-bit fetched words into 128-bit AES blocks, buffers them in a small
// FIFO and throttles the fetch master while a completed block cannot be stored.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] word_in,
  input  logic              end_block,
  input  logic              blk_ready,
  output logic              blk_valid,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_last,
  output logic              fetch_en,
  output logic              overflow
);

  pack_state_t       state_r;
  pack_state_t       state_next_s;
  logic [WCNT_W-1:0] wcnt_r;
  logic [WCNT_W-1:0] wcnt_next_s;
  aes_block_t        fill_r;
  aes_block_t        fill_next_s;
  logic              last_r;
  logic              last_next_s;
  logic              fetch_en_r;
  logic              overflow_r;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              pop_s;
  logic              room_s;
  logic              push_s;
  aes_block_t        push_data_s;
  logic              push_last_s;
  logic              ovf_set_s;
  aes_block_t        merged_s;
  logic [WCNT_W-1:0] cnt_after_s;
  logic              complete_s;

  assign pop_s     = ~fifo_empty_s & blk_ready;
  // A slot is available if the FIFO is not full or its head leaves this cycle.
  assign room_s    = ~fifo_full_s | pop_s;
  assign blk_valid = ~fifo_empty_s;
  assign fetch_en  = fetch_en_r;
  assign overflow  = overflow_r;

  aes_blk_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .push       (push_s),
    .push_entry ({push_last_s, push_data_s}),
    .pop        (pop_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .head_data  (blk_data),
    .head_last  (blk_last)
  );

  // Fill-side next state: word insertion, zero padding on end_block, commit or hold.
  always_comb begin
    state_next_s = state_r;
    wcnt_next_s  = wcnt_r;
    fill_next_s  = fill_r;
    last_next_s  = last_r;
    push_s       = 1'b0;
    push_data_s  = fill_r;
    push_last_s  = last_r;
    ovf_set_s    = 1'b0;
    merged_s     = fill_r;
    cnt_after_s  = wcnt_r;
    complete_s   = 1'b0;
    case (state_r)
      IDLE, FILL: begin
        if (shift_en) begin
          merged_s    = put_word(fill_r, wcnt_r, word_in);
          cnt_after_s = wcnt_r + WCNT_W'(1);
        end else begin
          merged_s    = fill_r;
          cnt_after_s = wcnt_r;
        end
        // The fill register is zero outside written slots, so padding is implicit.
        complete_s = (cnt_after_s == WCNT_W'(WPB)) ||
                     (end_block && (cnt_after_s != {WCNT_W{1'b0}}));
        if (complete_s) begin
          push_data_s = merged_s;
          push_last_s = end_block;
          if (room_s) begin
            push_s       = 1'b1;
            state_next_s = IDLE;
            wcnt_next_s  = {WCNT_W{1'b0}};
            fill_next_s  = {BLK_W{1'b0}};
            last_next_s  = 1'b0;
          end else begin
            state_next_s = HOLD;
            wcnt_next_s  = WCNT_W'(WPB);
            fill_next_s  = merged_s;
            last_next_s  = end_block;
          end
        end else if (cnt_after_s != {WCNT_W{1'b0}}) begin
          state_next_s = FILL;
          wcnt_next_s  = cnt_after_s;
          fill_next_s  = merged_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD: begin
        push_data_s = fill_r;
        push_last_s = last_r | end_block;
        if (room_s) begin
          push_s      = 1'b1;
          last_next_s = 1'b0;
          // A word arriving on the commit cycle starts the next block.
          if (shift_en) begin
            fill_next_s  = put_word({BLK_W{1'b0}}, {WCNT_W{1'b0}}, word_in);
            wcnt_next_s  = WCNT_W'(1);
            state_next_s = FILL;
          end else begin
            fill_next_s  = {BLK_W{1'b0}};
            wcnt_next_s  = {WCNT_W{1'b0}};
            state_next_s = IDLE;
          end
        end else begin
          last_next_s = last_r | end_block;
          ovf_set_s   = shift_en;
        end
      end
      default: begin
        state_next_s = IDLE;
        wcnt_next_s  = {WCNT_W{1'b0}};
        fill_next_s  = {BLK_W{1'b0}};
        last_next_s  = 1'b0;
      end
    endcase
  end

  // Fill-side state, registered fetch_en (low exactly while holding) and sticky overflow.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= IDLE;
      wcnt_r     <= {WCNT_W{1'b0}};
      fill_r     <= {BLK_W{1'b0}};
      last_r     <= 1'b0;
      fetch_en_r <= 1'b1;
      overflow_r <= 1'b0;
    end else if (clear) begin
      state_r    <= IDLE;
      wcnt_r     <= {WCNT_W{1'b0}};
      fill_r     <= {BLK_W{1'b0}};
      last_r     <= 1'b0;
      fetch_en_r <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wcnt_r     <= wcnt_next_s;
      fill_r     <= fill_next_s;
      last_r     <= last_next_s;
      fetch_en_r <= (state_next_s != HOLD);
      overflow_r <= overflow_r | ovf_set_s;
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: a queue-based reference model of the
// packer is stepped every clock and compared with the DUT every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_aes_block_packer;

  localparam int DEPTH = 2;

  logic         clk;
  logic         n_rst;
  logic         clear;
  logic         shift_en;
  logic [31:0]  word_in;
  logic         end_block;
  logic         blk_ready;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_last;
  logic         fetch_en;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  aes_block_packer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .shift_en  (shift_en),
    .word_in   (word_in),
    .end_block (end_block),
    .blk_ready (blk_ready),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .fetch_en  (fetch_en),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [128:0] mq[$];     // buffered blocks {last, data}, head first
  logic [31:0]  part[$];   // words of the block being filled
  bit           held;
  logic [128:0] hblk;
  bit           movf;

  task automatic model_reset();
    mq.delete();
    part.delete();
    held = 0;
    hblk = '0;
    movf = 0;
  endtask

  task automatic model_step();
    bit pop, room;
    logic [127:0] b;
    if (clear) begin
      model_reset();
      return;
    end
    pop  = (mq.size() > 0) && blk_ready;
    room = (mq.size() < DEPTH) || pop;
    if (pop) mq.delete(0);
    if (held) begin
      hblk[128] = hblk[128] | end_block;
      if (room) begin
        mq.push_back(hblk);
        held = 0;
        if (shift_en) part.push_back(word_in);
      end else if (shift_en) begin
        movf = 1;
      end
    end else begin
      if (shift_en) part.push_back(word_in);
      if (part.size() == 4 || (end_block && part.size() > 0)) begin
        b = '0;
        for (int i = 0; i < part.size(); i++) b[127-32*i -: 32] = part[i];
        part.delete();
        if (room) mq.push_back({end_block, b});
        else begin
          held = 1;
          hblk = {end_block, b};
        end
      end
    end
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) model_reset();
    else model_step();
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (n_rst && chk_en) begin
      chk("blk_valid", {127'd0, blk_valid}, {127'd0, (mq.size() > 0)});
      chk("fetch_en",  {127'd0, fetch_en},  {127'd0, !held});
      chk("overflow",  {127'd0, overflow},  {127'd0, movf});
      if (mq.size() > 0) begin
        chk("blk_data", blk_data, mq[0][127:0]);
        chk("blk_last", {127'd0, blk_last}, {127'd0, mq[0][128]});
      end
    end
  end

  task automatic drive(input bit se, input logic [31:0] w, input bit eb, input bit rdy);
    shift_en  = se;
    word_in   = w;
    end_block = eb;
    blk_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 32'h0, 0, rdy);
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; shift_en = 1'b0; word_in = 32'h0;
    end_block = 1'b0; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fetch_en", {127'd0, fetch_en}, 128'd1);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_blk_valid", {127'd0, blk_valid}, 128'd0);
    chk("rst_blk_data",  blk_data, 128'd0);
    chk("rst_blk_last",  {127'd0, blk_last}, 128'd0);
    chk("rst_overflow",  {127'd0, overflow}, 128'd0);
    chk_en = 1;

    // 1: full block of four words
    drive(1, 32'h00112233, 0, 1);
    drive(1, 32'h44556677, 0, 1);
    drive(1, 32'h8899AABB, 0, 1);
    chk("t1_not_yet_valid", {127'd0, blk_valid}, 128'd0);
    drive(1, 32'hCCDDEEFF, 0, 1);
    chk("t1_valid", {127'd0, blk_valid}, 128'd1);
    chk("t1_data", blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t1_last", {127'd0, blk_last}, 128'd0);
    idle(2, 1);

    // 2: short block padded by end_block
    drive(1, 32'h1, 0, 1);
    drive(1, 32'h2, 1, 1);
    chk("t2_valid", {127'd0, blk_valid}, 128'd1);
    chk("t2_data", blk_data, 128'h00000001_00000002_00000000_00000000);
    chk("t2_last", {127'd0, blk_last}, 128'd1);
    idle(2, 1);

    // 3: back-pressure, third block held
    for (int i = 0; i < 12; i++) drive(1, 32'h100 + i, 0, 0);
    chk("t3_fetch_en_low", {127'd0, fetch_en}, 128'd0);
    chk("t3_no_overflow", {127'd0, overflow}, 128'd0);
    chk("t3_head", blk_data, 128'h00000100_00000101_00000102_00000103);
    idle(1, 0);
    idle(1, 1);
    chk("t3_fetch_en_back", {127'd0, fetch_en}, 128'd1);
    chk("t3_head2", blk_data, 128'h00000104_00000105_00000106_00000107);
    idle(4, 1);

    // 4: late word while holding sets overflow; clear flushes everything
    for (int i = 0; i < 12; i++) drive(1, 32'h200 + i, 0, 0);
    idle(1, 0);
    drive(1, 32'hDEAD, 0, 0);
    chk("t4_overflow", {127'd0, overflow}, 128'd1);
    idle(2, 0);
    chk("t4_overflow_sticky", {127'd0, overflow}, 128'd1);
    clear = 1'b1;
    idle(1, 0);
    clear = 1'b0;
    chk("t4_clr_overflow", {127'd0, overflow}, 128'd0);
    chk("t4_clr_valid", {127'd0, blk_valid}, 128'd0);
    chk("t4_clr_fetch_en", {127'd0, fetch_en}, 128'd1);
    chk("t4_clr_data", blk_data, 128'd0);

    // 5: full FIFO, pop in the same cycle as the 4th word of the next block
    for (int i = 0; i < 11; i++) drive(1, 32'h300 + i, 0, 0);
    drive(1, 32'h30B, 0, 1);
    chk("t5_fetch_en", {127'd0, fetch_en}, 128'd1);
    chk("t5_overflow", {127'd0, overflow}, 128'd0);
    chk("t5_head", blk_data, 128'h00000304_00000305_00000306_00000307);
    idle(4, 1);

    // 6: async reset mid-block, then a fresh block
    drive(1, 32'hA, 0, 0);
    drive(1, 32'hB, 0, 0);
    n_rst = 1'b0;
    idle(2, 0);
    n_rst = 1'b1;
    idle(1, 0);
    for (int i = 0; i < 4; i++) drive(1, 32'hC0 + i, 0, 0);
    chk("t6_data", blk_data, 128'h000000C0_000000C1_000000C2_000000C3);
    chk("t6_last", {127'd0, blk_last}, 128'd0);
    idle(3, 1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit se;
      se = ($urandom_range(0, 9) < 6) && (fetch_en || ($urandom_range(0, 3) == 0));
      clear = ($urandom_range(0, 99) == 0);
      drive(se, $urandom, ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1);
    end
    clear = 1'b0;
    idle(6, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
